// File: rtl/affine_pkg.sv
// Shared sizes, state encoding and coefficient-code fields
// for the affine MCM FIR scheduler.
package affine_pkg;

    localparam int TAPS     = 6;
    localparam int PHASE_W  = 4;
    localparam int CODE_W   = 5;
    localparam int SAMPLE_W = 8;
    localparam int ACC_W    = 18;
    localparam int PROD_W   = SAMPLE_W + 6;
    localparam int NPHASE   = 1 << PHASE_W;

    localparam int SIGN_BIT = 4;
    localparam int IDX_HI   = 3;
    localparam int IDX_LO   = 0;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    function automatic logic [IDX_HI-IDX_LO:0] code_idx(
        input logic [CODE_W-1:0] c
    );
        return c[IDX_HI:IDX_LO];
    endfunction

    function automatic logic code_neg(input logic [CODE_W-1:0] c);
        return c[SIGN_BIT];
    endfunction

endpackage

// File: rtl/affine_mcm_sched_mcm.sv
// Multiplierless constant-multiplier block: one input sample,
// fifteen fixed products built from shared shift-add terms.
module A4_affine
    import affine_pkg::*;
(
    input  logic signed [SAMPLE_W-1:0] x,
    output logic signed [PROD_W-1:0]   y1,
    output logic signed [PROD_W-1:0]   y2,
    output logic signed [PROD_W-1:0]   y3,
    output logic signed [PROD_W-1:0]   y4,
    output logic signed [PROD_W-1:0]   y5,
    output logic signed [PROD_W-1:0]   y6,
    output logic signed [PROD_W-1:0]   y7,
    output logic signed [PROD_W-1:0]   y8,
    output logic signed [PROD_W-1:0]   y9,
    output logic signed [PROD_W-1:0]   y10,
    output logic signed [PROD_W-1:0]   y11,
    output logic signed [PROD_W-1:0]   y12,
    output logic signed [PROD_W-1:0]   y13,
    output logic signed [PROD_W-1:0]   y14,
    output logic signed [PROD_W-1:0]   y15
);

    logic signed [PROD_W-1:0] xe;
    logic signed [PROD_W-1:0] x13;
    logic signed [PROD_W-1:0] x17;
    logic signed [PROD_W-1:0] x31;

    assign xe  = {{(PROD_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};

    // 13, 17 and 31 are the shared partial products
    assign x13 = (xe <<< 3) + (xe <<< 2) + xe;
    assign x17 = (xe <<< 4) + xe;
    assign x31 = (xe <<< 5) - xe;

    assign y1  = xe <<< 2;
    assign y2  = xe <<< 3;
    assign y3  = x13;
    assign y4  = x17;
    assign y5  = x13 <<< 1;
    assign y6  = x31;
    assign y7  = x17 <<< 1;
    assign y8  = (xe <<< 5) + (xe <<< 3);
    assign y9  = (xe <<< 5) + x13;
    assign y10 = x31 + (xe <<< 4);
    assign y11 = x13 <<< 2;
    assign y12 = (x31 <<< 1) - (xe <<< 2);
    assign y13 = (xe <<< 6) - (xe <<< 2);
    assign y14 = x31 <<< 1;
    assign y15 = (xe <<< 6) - xe;

endmodule

// File: rtl/affine_mcm_sched.sv
// Polyphase FIR tap scheduler: one time-shared MCM block,
// one tap per cycle, phase 0 bypasses the MAC loop.
module affine_mcm_sched #(
    parameter int TAPS  = affine_pkg::TAPS,
    parameter int ACC_W = affine_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_phase,
    input  logic [2:0]              cfg_tap,
    input  logic [4:0]              cfg_code,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_phase,
    input  logic [8*TAPS-1:0]       in_samples,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    busy
);

    import affine_pkg::*;

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    state_t                     state;
    logic [CODE_W-1:0]          tbl   [NPHASE][TAPS];
    logic [CODE_W-1:0]          codes [TAPS];
    logic signed [SAMPLE_W-1:0] smp   [TAPS];
    logic signed [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]           tap;

    logic                       accept;
    logic [CODE_W-1:0]          code;
    logic signed [SAMPLE_W-1:0] x;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    term;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    bypass;
    logic [SAMPLE_W-1:0]        s2;

    logic signed [PROD_W-1:0] p1, p2, p3, p4, p5;
    logic signed [PROD_W-1:0] p6, p7, p8, p9, p10;
    logic signed [PROD_W-1:0] p11, p12, p13, p14, p15;

    assign accept = in_valid && in_ready;
    assign code   = codes[tap];
    assign x      = smp[tap];

    A4_affine u_mcm (
        .x   (x),
        .y1  (p1),
        .y2  (p2),
        .y3  (p3),
        .y4  (p4),
        .y5  (p5),
        .y6  (p6),
        .y7  (p7),
        .y8  (p8),
        .y9  (p9),
        .y10 (p10),
        .y11 (p11),
        .y12 (p12),
        .y13 (p13),
        .y14 (p14),
        .y15 (p15)
    );

    always_comb begin
        prod = '0;
        case (code_idx(code))
            4'd1:    prod = p1;
            4'd2:    prod = p2;
            4'd3:    prod = p3;
            4'd4:    prod = p4;
            4'd5:    prod = p5;
            4'd6:    prod = p6;
            4'd7:    prod = p7;
            4'd8:    prod = p8;
            4'd9:    prod = p9;
            4'd10:   prod = p10;
            4'd11:   prod = p11;
            4'd12:   prod = p12;
            4'd13:   prod = p13;
            4'd14:   prod = p14;
            4'd15:   prod = p15;
            default: prod = '0;
        endcase
    end

    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign term     = code_neg(code) ? -prod_ext : prod_ext;
    assign sum      = acc + term;

    assign s2     = in_samples[2*SAMPLE_W +: SAMPLE_W];
    assign bypass = {{(ACC_W-SAMPLE_W-6){s2[SAMPLE_W-1]}}, s2, 6'b0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < NPHASE; p++) begin
                for (int t = 0; t < TAPS; t++) begin
                    tbl[p][t] <= '0;
                end
            end
        end else if (cfg_we && (int'(cfg_tap) < TAPS)) begin
            tbl[cfg_phase][cfg_tap] <= cfg_code;
        end
    end

    // Snapshot of row and samples uses pre-edge table contents,
    // so a same-cycle cfg write is not seen by this transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            acc       <= '0;
            tap       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        for (int k = 0; k < TAPS; k++) begin
                            codes[k] <= tbl[in_phase][k];
                            smp[k]   <= in_samples[k*SAMPLE_W +: SAMPLE_W];
                        end
                        acc      <= '0;
                        tap      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_phase == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= bypass;
                        end else begin
                            state <= MAC;
                        end
                    end
                end
                MAC: begin
                    acc <= sum;
                    if (tap == CNT_W'(TAPS-1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= sum;
                        tap       <= '0;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_affine_mcm_sched.sv
// Directed and random checks of affine_mcm_sched against a
// tap-by-tap arithmetic model of the coefficient table.
module tb_affine_mcm_sched;

    localparam int TAPS  = 6;
    localparam int ACC_W = 18;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_phase = '0;
    logic [2:0]        cfg_tap = '0;
    logic [4:0]        cfg_code = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_phase = '0;
    logic [8*TAPS-1:0] in_samples = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_data;
    logic              busy;

    affine_mcm_sched #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_phase  (cfg_phase),
        .cfg_tap    (cfg_tap),
        .cfg_code   (cfg_code),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_phase   (in_phase),
        .in_samples (in_samples),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int coef [16] = '{0, 4, 8, 13, 17, 26, 31, 34,
                      40, 45, 47, 52, 58, 60, 62, 63};
    int  ref_tbl [16][TAPS];
    byte smp [TAPS];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  t_acc = 0;
    int  exp_v = 0;
    int  exp_lat = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int ph);
        int s;
        s = 0;
        if (ph == 0) return int'(smp[2]) * 64;
        for (int k = 0; k < TAPS; k++) begin
            int c;
            int v;
            c = ref_tbl[ph][k];
            v = coef[c & 15] * int'(smp[k]);
            s += ((c & 16) != 0) ? -v : v;
        end
        return s;
    endfunction

    task automatic set_smp_all(input byte v);
        for (int k = 0; k < TAPS; k++) smp[k] = v;
    endtask

    task automatic pack();
        for (int k = 0; k < TAPS; k++) in_samples[8*k +: 8] = smp[k];
    endtask

    task automatic clear_ref();
        for (int p = 0; p < 16; p++)
            for (int t = 0; t < TAPS; t++) ref_tbl[p][t] = 0;
    endtask

    task automatic cfg_write(input int ph, input int tp, input int cd);
        cfg_we    = 1'b1;
        cfg_phase = 4'(ph);
        cfg_tap   = 3'(tp);
        cfg_code  = 5'(cd);
        tick();
        cfg_we = 1'b0;
        if (tp < TAPS) ref_tbl[ph][tp] = cd;
    endtask

    task automatic start_req(input string tag, input int ph);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        exp_v    = model(ph);
        exp_lat  = (ph == 0) ? 1 : TAPS + 1;
        in_phase = 4'(ph);
        pack();
        in_valid = 1'b1;
        t_acc    = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_req(input string tag, input int hold);
        logic [ACC_W-1:0] e;
        e = ACC_W'(exp_v);
        while (out_valid !== 1'b1 && cyc - t_acc < 40) tick();
        chk({tag, "_latency"}, 32'(cyc - t_acc), 32'(exp_lat));
        chk({tag, "_data"}, 32'(out_data), 32'(e));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            tick();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(out_data), 32'(e));
            chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        clear_ref();
        set_smp_all(8'sd0);

        // reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // basic MAC on row 5
        cfg_write(5, 0, 5'h00);
        cfg_write(5, 1, 5'h12);
        cfg_write(5, 2, 5'h0F);
        cfg_write(5, 3, 5'h01);
        cfg_write(5, 4, 5'h00);
        cfg_write(5, 5, 5'h00);
        set_smp_all(8'sd10);
        start_req("basic", 5);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_model", 32'(exp_v), 32'd590);
        finish_req("basic", 0);

        // extremes
        for (int t = 0; t < TAPS; t++) cfg_write(1, t, 5'h0F);
        for (int t = 0; t < TAPS; t++) cfg_write(2, t, 5'h1F);
        set_smp_all(-8'sd128);
        start_req("ext_neg", 1);
        finish_req("ext_neg", 0);
        start_req("ext_pos", 2);
        finish_req("ext_pos", 0);

        // phase-0 bypass
        set_smp_all(8'sd7);
        smp[2] = -8'sd5;
        start_req("phase0", 0);
        chk("phase0_busy", 32'(busy), 32'd1);
        finish_req("phase0", 0);

        // backpressure then immediate follow-up request
        set_smp_all(8'sd10);
        start_req("bp", 5);
        finish_req("bp", 3);
        start_req("bp_next", 5);
        finish_req("bp_next", 0);

        // rewrite row 5 in the middle of a MAC
        start_req("cfgmac", 5);
        tick();
        tick();
        chk("cfgmac_busy", 32'(busy), 32'd1);
        cfg_write(5, 1, 5'h03);
        finish_req("cfgmac", 0);
        start_req("cfgmac_new", 5);
        chk("cfgmac_new_model", 32'(exp_v), 32'd800);
        finish_req("cfgmac_new", 0);

        // same-cycle write and acceptance on row 7
        cfg_write(7, 0, 5'h01);
        set_smp_all(8'sd3);
        chk("same_ready", 32'(in_ready), 32'd1);
        exp_v     = model(7);
        exp_lat   = TAPS + 1;
        in_phase  = 4'd7;
        pack();
        cfg_we    = 1'b1;
        cfg_phase = 4'd7;
        cfg_tap   = 3'd0;
        cfg_code  = 5'h0F;
        in_valid  = 1'b1;
        t_acc     = cyc;
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        ref_tbl[7][0] = 5'h0F;
        finish_req("same_old", 0);
        start_req("same_new", 7);
        finish_req("same_new", 0);

        // out-of-range tap writes are dropped
        cfg_write(3, 6, 5'h0F);
        cfg_write(3, 7, 5'h0F);
        start_req("badtap", 3);
        finish_req("badtap", 0);

        // reset mid-MAC aborts and clears the table
        start_req("midrst", 5);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_ref();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        start_req("midrst_after", 5);
        finish_req("midrst_after", 0);

        // random table contents and samples
        for (int n = 0; n < 30; n++) begin
            for (int w = 0; w < 4; w++) begin
                cfg_write($urandom_range(0, 15), $urandom_range(0, 7),
                          $urandom_range(0, 31));
            end
            for (int k = 0; k < TAPS; k++) smp[k] = byte'($urandom);
            start_req("rand", $urandom_range(0, 15));
            finish_req("rand", $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/affine_mcm_sched.md
AFFINE_MCM_SCHED -- requirements
Module: affine_mcm_sched

Interface
REQ-001 Parameter TAPS, default 6, filter taps per output sample.
REQ-002 Parameter ACC_W, default 18, accumulator and output width in bits.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port cfg_we  input  1  coefficient-table write strobe.
REQ-006 Port cfg_phase  input  4  table row (fractional phase) to write.
REQ-007 Port cfg_tap  input  3  table column to write; values >= TAPS are ignored.
REQ-008 Port cfg_code  input  5  coefficient code: bit4 = sign (1 = negative), [3:0] = product index.
REQ-009 Port in_valid  input  1  request valid.
REQ-010 Port in_ready  output  1  request accepted when in_valid and in_ready are both high.
REQ-011 Port in_phase  input  4  fractional phase of the request.
REQ-012 Port in_samples  input  8*TAPS  signed 8-bit samples; sample k is at [8k+7:8k].
REQ-013 Port out_valid  output  1  result valid.
REQ-014 Port out_ready  input  1  consumer ready.
REQ-015 Port out_data  output  ACC_W  signed filtered result.
REQ-016 Port busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL use the states IDLE, MAC and DONE.
REQ-018 in_ready SHALL be 1 only in IDLE.
REQ-019 On acceptance, the block SHALL latch all TAPS codes of row in_phase and all samples; later cfg writes SHALL NOT affect the latched transaction.
REQ-020 For a non-zero phase accepted at cycle T, the FSM SHALL go to MAC and process tap k in cycle T+1+k.
REQ-021 Each MAC cycle SHALL add the term for tap k to the accumulator.
REQ-022 The term for tap k SHALL be the MCM product selected by the index for sample k, negated if sign=1, sign-extended to ACC_W.
REQ-023 MCM index 1..15 SHALL select X times {4, 8, 13, 17, 26, 31, 34, 40, 45, 47, 52, 58, 60, 62, 63} in that order.
REQ-024 Index 0 SHALL contribute 0 regardless of sign.
REQ-025 The accumulator SHALL clear on acceptance.
REQ-026 After the last tap the FSM SHALL enter DONE, with out_valid=1 at cycle T+TAPS+1 (T+7 for the default).
REQ-027 A phase-0 request SHALL bypass MAC: out_data = sample[2] << 6, sign-extended, with out_valid=1 at T+1.
REQ-028 In DONE, out_valid and out_data SHALL hold stable until out_ready=1; the FSM then returns to IDLE on the next edge.
REQ-029 A new request SHALL be acceptable no earlier than the cycle after the output handshake.
REQ-030 ACC_W=18 SHALL represent the extreme sum +/-48384 (6 x 63 x 128) exactly, with no saturation logic.
REQ-031 A cfg write SHALL update the table at the next edge in any FSM state.
REQ-032 If a cfg write and an acceptance target the same row in the same cycle, the latched codes SHALL be the pre-write values.

Reset
REQ-033 While rst_n=0 at an edge, the block SHALL set: state IDLE, out_valid=0, out_data=0, busy=0, accumulator=0, tap counter=0.
REQ-034 While rst_n=0 at an edge, every table entry SHALL be set to code 0.
REQ-035 Reset asserted during MAC or DONE SHALL abort the transaction with no output handshake.
REQ-036 in_ready SHALL read 1 in the first cycle after rst_n returns high.

Structure
REQ-037 Package affine_pkg SHALL hold TAPS, PHASE_W=4, CODE_W=5, SAMPLE_W=8, ACC_W, the state enum and the code field positions (sign bit, index slice).
REQ-038 The block SHALL instantiate exactly one A4_affine MCM (X = current tap sample, Y1..Y15 = products), time-shared across taps.
REQ-039 The coefficient table SHALL be a 16 x TAPS register array inside affine_mcm_sched, with no separate memory macro.

Verification
REQ-040 Reset: hold rst_n=0 mid-MAC for 1 cycle -> next cycle out_valid=0, busy=0, in_ready=1, and a phase-5 request yields 0.
REQ-041 Basic MAC: row 5 = {0, -idx2, +idx15, +idx1, 0, 0}, all samples = 10 -> out_data=590 with out_valid at T+7.
REQ-042 Extreme: all codes +idx15, all samples -128 -> out_data=-48384; all codes -idx15 -> +48384.
REQ-043 Phase 0: sample[2]=-5 -> out_data=-320 at T+1, with no MAC cycles.
REQ-044 Backpressure: out_ready=0 for 3 cycles -> out_valid and out_data stable, in_ready=0; next request accepted the cycle after the handshake.
REQ-045 Config during MAC: rewrite row 5 at cycle T+3 -> current result still 590, and the following phase-5 request uses the new codes.
